// File: rtl/mips_multicycle_ctrl.sv
// rtl/mips_multicycle_ctrl.sv - Moore main control FSM for the multicycle MIPS-1 core
// Steps each instruction through fetch/decode/execute states and drives datapath controls.
module mips_multicycle_ctrl #(
    parameter bit MEM_HANDSHAKE = 1'b1
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [5:0] op_i,
    input  logic       mem_ready_i,
    output logic       mem_req_o,
    output logic       IorD_o,
    output logic       MemWrite_o,
    output logic       IRWrite_o,
    output logic       PCWrite_o,
    output logic       Branch_o,
    output logic [1:0] PCSrc_o,
    output logic       AluSrcA_o,
    output logic [1:0] AluSrcB_o,
    output logic [1:0] AluOp_o,
    output logic       RegDst_o,
    output logic       MemtoReg_o,
    output logic       RegWrite_o,
    output logic       illegal_o
);

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;

    typedef enum logic [3:0] {
        S_RESET, S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
        S_EXEC, S_ALUWB, S_BRANCH, S_ADDIEX, S_ADDIWB, S_JUMP
    } state_t;

    typedef struct packed {
        logic       mem_req;
        logic       iord;
        logic       mem_write;
        logic       ir_write;
        logic       pc_write;
        logic       branch;
        logic [1:0] pc_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
    } ctrl_t;

    state_t state_q, state_d;
    ctrl_t  ctrl_q;
    logic   ready;
    logic   op_legal;

    assign ready    = MEM_HANDSHAKE ? mem_ready_i : 1'b1;
    assign op_legal = (op_i == OP_R) || (op_i == OP_J) || (op_i == OP_BEQ) ||
                      (op_i == OP_ADDI) || (op_i == OP_LW) || (op_i == OP_SW);

    function automatic ctrl_t ctrl_of(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.mem_req   = 1'b1;
                c.alu_src_b = 2'b01;
                c.ir_write  = 1'b1;
                c.pc_write  = 1'b1;
            end
            S_DECODE: c.alu_src_b = 2'b11;
            S_MEMADR, S_ADDIEX: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
            end
            S_MEMRD: begin
                c.mem_req = 1'b1;
                c.iord    = 1'b1;
            end
            S_MEMWB: begin
                c.mem_to_reg = 1'b1;
                c.reg_write  = 1'b1;
            end
            S_MEMWR: begin
                c.mem_req   = 1'b1;
                c.iord      = 1'b1;
                c.mem_write = 1'b1;
            end
            S_EXEC: begin
                c.alu_src_a = 1'b1;
                c.alu_op    = 2'b10;
            end
            S_ALUWB: begin
                c.reg_dst   = 1'b1;
                c.reg_write = 1'b1;
            end
            S_BRANCH: begin
                c.alu_src_a = 1'b1;
                c.alu_op    = 2'b01;
                c.pc_src    = 2'b01;
                c.branch    = 1'b1;
            end
            S_ADDIWB: c.reg_write = 1'b1;
            S_JUMP: begin
                c.pc_src   = 2'b10;
                c.pc_write = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RESET:  state_d = S_FETCH;
            S_FETCH:  if (ready) state_d = S_DECODE;
            S_DECODE: begin
                case (op_i)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR: state_d = (op_i == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  if (ready) state_d = S_MEMWB;
            S_MEMWR:  if (ready) state_d = S_FETCH;
            S_EXEC:   state_d = S_ALUWB;
            S_ADDIEX: state_d = S_ADDIWB;
            S_MEMWB, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP: state_d = S_FETCH;
            default:  state_d = S_RESET;
        endcase
    end

    // Outputs are registered from the next state so they line up with state_q.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_RESET;
            ctrl_q  <= '0;
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_of(state_d);
        end
    end

    // Only the FETCH write enables wait on memory; the JUMP PC write is unconditional.
    logic fetch_gate;
    assign fetch_gate = (state_q != S_FETCH) || ready;

    assign mem_req_o  = ctrl_q.mem_req;
    assign IorD_o     = ctrl_q.iord;
    assign MemWrite_o = ctrl_q.mem_write;
    assign IRWrite_o  = ctrl_q.ir_write & fetch_gate;
    assign PCWrite_o  = ctrl_q.pc_write & fetch_gate;
    assign Branch_o   = ctrl_q.branch;
    assign PCSrc_o    = ctrl_q.pc_src;
    assign AluSrcA_o  = ctrl_q.alu_src_a;
    assign AluSrcB_o  = ctrl_q.alu_src_b;
    assign AluOp_o    = ctrl_q.alu_op;
    assign RegDst_o   = ctrl_q.reg_dst;
    assign MemtoReg_o = ctrl_q.mem_to_reg;
    assign RegWrite_o = ctrl_q.reg_write;
    assign illegal_o  = (state_q == S_DECODE) && !op_legal;

endmodule
